// File: rtl/snake_dir_if.sv
// snake_dir_if
//   Bundles the turn-scheduler signals between the button pulse generators,
//   the game sequencer and the snake movement engine.
//   Signals:
//     btn_pulse [3:0]    1-cycle pulses; [0]=up [1]=right [2]=down [3]=left
//     run                game active level
//     tick               1-cycle game-step strobe
//     dir [1:0]          current heading; 0=up 1=right 2=down 3=left
//     step               1-cycle strobe: advance snake one cell using dir
//     q_count [CNT_W-1:0] turns currently buffered
//     drop_cnt [7:0]     dropped-request count (SNAKE_DIR_DROPCNT_EN only)
//   Modports: master drives the requests and observes the outputs;
//   slave is the scheduler side.
interface snake_dir_if #(
   parameter int CNT_W = 2
);
   logic [3:0]       btn_pulse;
   logic             run;
   logic             tick;
   logic [1:0]       dir;
   logic             step;
   logic [CNT_W-1:0] q_count;
`ifdef SNAKE_DIR_DROPCNT_EN
   logic [7:0]       drop_cnt;
`endif

`ifdef SNAKE_DIR_DROPCNT_EN
   modport master (output btn_pulse, run, tick, input dir, step, q_count, drop_cnt);
   modport slave  (input btn_pulse, run, tick, output dir, step, q_count, drop_cnt);
`else
   modport master (output btn_pulse, run, tick, input dir, step, q_count);
   modport slave  (input btn_pulse, run, tick, output dir, step, q_count);
`endif
endinterface

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
//   Turn scheduler between the button pulse generators and the snake movement
//   engine. Round-robin arbitrates simultaneous button pulses, rejects no-op
//   and 180-degree turns, buffers accepted turns in a QDEPTH-entry FIFO and
//   releases one turn per game tick.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high
//     bus    snake_dir_if.slave (btn_pulse, run, tick in; dir, step, q_count out)
//   Optional feature: define SNAKE_DIR_DROPCNT_EN to add an 8-bit saturating
//   count of cycles in which a button request was not enqueued (bus.drop_cnt).
//
//   state | meaning
//   IDLE  | game stopped; buttons and ticks ignored, waits for run
//   RUN   | arbitrate/enqueue turns, step and pop on tick; run=0 flushes
module snake_dir_ctrl #(
   parameter int         QDEPTH   = 2,
   parameter int         CNT_W    = 2,
   parameter logic [1:0] INIT_DIR = 2'd1
) (
   input  logic        clk,
   input  logic        reset,
   snake_dir_if.slave  bus
);
   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [1:0]       dir_q, dir_d;
   logic             step_q, step_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [1:0]       rr_q, rr_d;
   logic [1:0]       fifo_q [QDEPTH];
   logic [1:0]       fifo_d [QDEPTH];

   logic             found, push, pop, full;
   logic [1:0]       win, idx, ref_dir;
   logic [PTR_W-1:0] tail_idx;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

`ifdef SNAKE_DIR_DROPCNT_EN
   logic [7:0] drop_q, drop_d;
   logic       drop_ev;
`endif

   assign full     = (count_q == CNT_W'(QDEPTH));
   // Most recently pushed entry; only meaningful when count_q != 0.
   assign tail_idx = (wr_q == '0) ? PTR_W'(QDEPTH - 1) : wr_q - 1'b1;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      count_d = count_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      rr_d    = rr_q;
      fifo_d  = fifo_q;
      push    = 1'b0;
      pop     = 1'b0;
      found   = 1'b0;
      win     = 2'd0;
      idx     = 2'd0;
`ifdef SNAKE_DIR_DROPCNT_EN
      drop_d  = drop_q;
      drop_ev = 1'b0;
`endif

      // Round-robin search starting at rr_q.
      for (int i = 0; i < 4; i++) begin
         idx = rr_q + 2'(i);
         if (!found && bus.btn_pulse[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end

      // Legality is judged against where the snake will be heading after all
      // buffered turns, i.e. the pre-pop tail.
      ref_dir = (count_q != '0) ? fifo_q[tail_idx] : dir_q;

      case (state_q)
         IDLE: begin
            if (bus.run) state_d = RUN;
         end
         RUN: begin
            pop    = bus.tick && (count_q != '0);
            step_d = bus.tick;
            if (found) begin
               rr_d = win + 2'd1;
               push = (win != ref_dir) && (win != (ref_dir ^ 2'b10)) && (!full || pop);
`ifdef SNAKE_DIR_DROPCNT_EN
               // Losers of arbitration count as drops even if the winner is taken.
               drop_ev = !push || ((bus.btn_pulse & (bus.btn_pulse - 4'd1)) != 4'd0);
`endif
            end
            if (pop) begin
               dir_d = fifo_q[rd_q];
               rd_d  = ptr_inc(rd_q);
            end
            if (push) begin
               fifo_d[wr_q] = win;
               wr_d         = ptr_inc(wr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            // A tick coinciding with run falling still pops; the rest is flushed.
            if (!bus.run) begin
               state_d = IDLE;
               count_d = '0;
               wr_d    = '0;
               rd_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef SNAKE_DIR_DROPCNT_EN
      if (drop_ev && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         dir_q   <= INIT_DIR;
         step_q  <= 1'b0;
         count_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         rr_q    <= 2'd0;
         for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= 2'd0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         count_q <= count_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         rr_q    <= rr_d;
         fifo_q  <= fifo_d;
      end
   end

`ifdef SNAKE_DIR_DROPCNT_EN
   always_ff @(posedge clk) begin
      if (reset) drop_q <= 8'd0;
      else       drop_q <= drop_d;
   end
   assign bus.drop_cnt = drop_q;
`endif

   assign bus.dir     = dir_q;
   assign bus.step    = step_q;
   assign bus.q_count = count_q;
endmodule
